// File: rtl/gen_step_ctrl_if.sv
// gen_step_ctrl_if: trigger inputs, update-engine handshake and status outputs of gen_step_ctrl
interface gen_step_ctrl_if #(
    parameter int GEN_W = 16,
    parameter int OVR_W = 8
);
    logic             tick_in;
    logic             run;
    logic             step_btn;
    logic             clear;
    logic             step_ack;
    logic             step_req;
    logic [GEN_W-1:0] gen_count;
    logic             overrun;
    logic [OVR_W-1:0] ovr_count;

    modport master (
        output tick_in, run, step_btn, clear, step_ack,
        input  step_req, gen_count, overrun, ovr_count
    );

    modport slave (
        input  tick_in, run, step_btn, clear, step_ack,
        output step_req, gen_count, overrun, ovr_count
    );
endinterface

// File: rtl/gen_step_ctrl.sv
// gen_step_ctrl: syncs the generation tick, turns ticks or manual steps into a req/ack handshake, counts generations and drops
// Define OVERRUN_CNT_EN to add a saturating dropped-trigger counter on ovr_count (tied to 0 otherwise).
module gen_step_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int GEN_W       = 16,
    parameter int OVR_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    gen_step_ctrl_if.slave bus
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_t_prev, r_b_prev, r_overrun;
    logic [GEN_W-1:0]       r_gen;
    logic                   w_tick_pulse, w_step_edge, w_trigger, w_done, w_drop;

    assign w_tick_pulse = r_sync[SYNC_STAGES-1] & ~r_t_prev;
    assign w_step_edge  = bus.step_btn & ~r_b_prev;
    assign w_trigger    = bus.run ? w_tick_pulse : w_step_edge;
    assign w_done       = (r_state == REQ) & bus.step_ack;
    // A trigger arriving while a request is in flight is dropped, even on the acking cycle
    assign w_drop       = (r_state == REQ) & w_trigger;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '0;
            r_t_prev <= 1'b0;
            r_b_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.tick_in};
            r_t_prev <= r_sync[SYNC_STAGES-1];
            r_b_prev <= bus.step_btn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (w_trigger ? REQ : IDLE) : (bus.step_ack ? IDLE : REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gen     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_gen     <= bus.clear ? '0 : (w_done ? r_gen + 1'b1 : r_gen);
            r_overrun <= bus.clear ? 1'b0 : (r_overrun | w_drop);
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [OVR_W-1:0] r_ovr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ovr <= '0;
        else if (bus.clear) r_ovr <= '0;
        else if (w_drop && r_ovr != '1) r_ovr <= r_ovr + 1'b1;
    end

    assign bus.ovr_count = r_ovr;
`else
    assign bus.ovr_count = OVR_W'(0);
`endif

    assign bus.step_req  = (r_state == REQ);
    assign bus.gen_count = r_gen;
    assign bus.overrun   = r_overrun;
endmodule
